// File: rtl/spi_lcd_cmd_decoder_if.sv
// Byte-stream in / pixel + register-state out bundle for the LCD command decoder.
// Latency: none (wiring only).
// Backpressure: pixel path uses o_pix_valid/i_pix_ready; byte path has none.
//
// Ports (via modports):
//   master : the decoder side. It receives SPI bytes, CS-release strobes and
//            the pixel ready, and drives pixel data, window and state outputs.
//   slave  : the environment side (SPI receiver + frame-buffer writer).
interface spi_lcd_cmd_decoder_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        i_spi_data;
  logic              i_spi_rxdone;
  logic              i_spi_csreleased;
  logic [17:0]       o_pix_data;
  logic              o_pix_valid;
  logic              i_pix_ready;
  logic              o_ramwr_start;
  logic [ADDR_W-1:0] o_col_start;
  logic [ADDR_W-1:0] o_col_end;
  logic [ADDR_W-1:0] o_row_start;
  logic [ADDR_W-1:0] o_row_end;
  logic              o_waddr_set;
  logic              o_sram_clr_req;
  logic              o_disp_on;
  logic              o_invert;
  logic [7:0]        o_madctl;
  logic              o_bpp18;
  logic              o_overflow;

  modport master (
    input  i_spi_data, i_spi_rxdone, i_spi_csreleased, i_pix_ready,
    output o_pix_data, o_pix_valid, o_ramwr_start,
    output o_col_start, o_col_end, o_row_start, o_row_end, o_waddr_set,
    output o_sram_clr_req, o_disp_on, o_invert, o_madctl, o_bpp18, o_overflow
  );

  modport slave (
    output i_spi_data, i_spi_rxdone, i_spi_csreleased, i_pix_ready,
    input  o_pix_data, o_pix_valid, o_ramwr_start,
    input  o_col_start, o_col_end, o_row_start, o_row_end, o_waddr_set,
    input  o_sram_clr_req, o_disp_on, o_invert, o_madctl, o_bpp18, o_overflow
  );
endinterface

// File: rtl/spi_lcd_cmd_decoder.sv
// ST7735R/ILI-style SPI byte-stream decoder: register state, atomic window commits, RGB666 pixels.
// Latency: every effect is registered and appears one cycle after the decoding i_spi_rxdone.
// Backpressure: pixel held on o_pix_valid until i_pix_ready; a pixel completing while one is held is dropped and o_overflow set.
//
// Ports: i_clk, i_rst (async, active-high) plus the interface bus (master modport):
//   bytes in (i_spi_data/i_spi_rxdone/i_spi_csreleased), pixel out (o_pix_*/i_pix_ready),
//   window outputs + o_waddr_set, o_ramwr_start, o_sram_clr_req and display state.
module spi_lcd_cmd_decoder #(
  parameter int ADDR_W        = 16,
  parameter int CLR_PULSE_LEN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  spi_lcd_cmd_decoder_if.master bus
);

  localparam int CLR_W = $clog2(CLR_PULSE_LEN + 1);

  localparam logic [7:0] CMD_SWRESET  = 8'h01;
  localparam logic [7:0] CMD_INVOFF   = 8'h20;
  localparam logic [7:0] CMD_INVON    = 8'h21;
  localparam logic [7:0] CMD_GAMMASET = 8'h26;
  localparam logic [7:0] CMD_DISPOFF  = 8'h28;
  localparam logic [7:0] CMD_DISPON   = 8'h29;
  localparam logic [7:0] CMD_CASET    = 8'h2A;
  localparam logic [7:0] CMD_RASET    = 8'h2B;
  localparam logic [7:0] CMD_RAMWR    = 8'h2C;
  localparam logic [7:0] CMD_MADCTL   = 8'h36;
  localparam logic [7:0] CMD_COLMOD   = 8'h3A;
  localparam logic [7:0] CMD_FRMCTR1  = 8'hB1;
  localparam logic [7:0] CMD_FRMCTR2  = 8'hB2;
  localparam logic [7:0] CMD_FRMCTR3  = 8'hB3;
  localparam logic [7:0] CMD_INVCTR   = 8'hB4;
  localparam logic [7:0] CMD_PWCTR1   = 8'hC0;
  localparam logic [7:0] CMD_PWCTR2   = 8'hC1;
  localparam logic [7:0] CMD_PWCTR3   = 8'hC2;
  localparam logic [7:0] CMD_PWCTR4   = 8'hC3;
  localparam logic [7:0] CMD_PWCTR5   = 8'hC4;
  localparam logic [7:0] CMD_VMCTR1   = 8'hC5;
  localparam logic [7:0] CMD_VMOFCTR  = 8'hC7;
  localparam logic [7:0] CMD_WRID2    = 8'hD1;
  localparam logic [7:0] CMD_WRID3    = 8'hD2;
  localparam logic [7:0] CMD_NVCTR1   = 8'hD9;
  localparam logic [7:0] CMD_NVCTR3   = 8'hDF;
  localparam logic [7:0] CMD_GAMCTRP1 = 8'hE0;
  localparam logic [7:0] CMD_GAMCTRN1 = 8'hE1;

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ARGS,
    ST_PIXEL
  } state_e;

  // Number of argument bytes that follow each command byte.
  function automatic logic [4:0] arg_count(input logic [7:0] c);
    case (c)
      CMD_GAMMASET, CMD_MADCTL, CMD_COLMOD, CMD_INVCTR, CMD_PWCTR2,
      CMD_VMCTR1, CMD_VMOFCTR, CMD_WRID2, CMD_WRID3, CMD_NVCTR1:
        arg_count = 5'd1;
      CMD_PWCTR3, CMD_PWCTR4, CMD_PWCTR5, CMD_NVCTR3:
        arg_count = 5'd2;
      CMD_FRMCTR1, CMD_FRMCTR2, CMD_PWCTR1:
        arg_count = 5'd3;
      CMD_CASET, CMD_RASET:
        arg_count = 5'd4;
      CMD_FRMCTR3:
        arg_count = 5'd6;
      CMD_GAMCTRP1, CMD_GAMCTRN1:
        arg_count = 5'd16;
      default:
        arg_count = 5'd0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [4:0]        arg_cnt_q, arg_cnt_d;
  logic [1:0]        pix_cnt_q, pix_cnt_d;
  logic [7:0]        pix_hi_q, pix_hi_d;
  logic [5:0]        pix_mid_q, pix_mid_d;
  // Holds the first three window bytes; the fourth arrives live on i_spi_data,
  // so {shadow_q, byte} is the full 32-bit {start, end} word.
  logic [23:0]       shadow_q, shadow_d;
  logic [17:0]       pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic              ramwr_start_q, ramwr_start_d;
  logic [ADDR_W-1:0] col_start_q, col_start_d;
  logic [ADDR_W-1:0] col_end_q, col_end_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;
  logic [ADDR_W-1:0] row_end_q, row_end_d;
  logic              waddr_set_q, waddr_set_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              sram_clr_req_q, sram_clr_req_d;
  logic              disp_on_q, disp_on_d;
  logic              invert_q, invert_d;
  logic [7:0]        madctl_q, madctl_d;
  logic              bpp18_q, bpp18_d;
  logic              overflow_q, overflow_d;

  logic [31:0]       win_word;
  logic              pix_done;
  logic [17:0]       pix_new;

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    arg_cnt_d      = arg_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    pix_hi_d       = pix_hi_q;
    pix_mid_d      = pix_mid_q;
    shadow_d       = shadow_q;
    pix_data_d     = pix_data_q;
    // A held pixel is released by the handshake; a new load below overrides.
    pix_valid_d    = pix_valid_q & ~bus.i_pix_ready;
    ramwr_start_d  = 1'b0;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    row_start_d    = row_start_q;
    row_end_d      = row_end_q;
    waddr_set_d    = 1'b0;
    clr_cnt_d      = (clr_cnt_q != '0) ? clr_cnt_q - CLR_W'(1) : '0;
    disp_on_d      = disp_on_q;
    invert_d       = invert_q;
    madctl_d       = madctl_q;
    bpp18_d        = bpp18_q;
    overflow_d     = overflow_q;
    win_word       = {shadow_q, bus.i_spi_data};
    pix_done       = 1'b0;
    pix_new        = '0;

    if (bus.i_spi_csreleased) begin
      // CS release wins over a same-cycle byte; committed state is kept.
      state_d   = ST_CMD;
      arg_cnt_d = '0;
      pix_cnt_d = '0;
      pix_hi_d  = '0;
      pix_mid_d = '0;
      shadow_d  = '0;
    end else if (bus.i_spi_rxdone) begin
      case (state_q)
        ST_CMD: begin
          cmd_d     = bus.i_spi_data;
          arg_cnt_d = '0;
          case (bus.i_spi_data)
            CMD_SWRESET: begin
              disp_on_d  = 1'b0;
              invert_d   = 1'b0;
              madctl_d   = '0;
              bpp18_d    = 1'b0;
              overflow_d = 1'b0;
              clr_cnt_d  = CLR_W'(CLR_PULSE_LEN);
            end
            CMD_DISPON:  disp_on_d = 1'b1;
            CMD_DISPOFF: disp_on_d = 1'b0;
            CMD_INVON:   invert_d  = 1'b1;
            CMD_INVOFF:  invert_d  = 1'b0;
            default: ;
          endcase
          if (bus.i_spi_data == CMD_RAMWR) begin
            state_d       = ST_PIXEL;
            ramwr_start_d = 1'b1;
            pix_cnt_d     = '0;
          end else if (arg_count(bus.i_spi_data) != 5'd0) begin
            state_d = ST_ARGS;
          end
        end

        ST_ARGS: begin
          arg_cnt_d = arg_cnt_q + 5'd1;
          if (arg_cnt_q == arg_count(cmd_q) - 5'd1) begin
            state_d = ST_CMD;
          end
          case (cmd_q)
            CMD_CASET, CMD_RASET: begin
              shadow_d = win_word[23:0];
              // Window outputs only change once all four bytes are in.
              if (arg_cnt_q == 5'd3) begin
                waddr_set_d = 1'b1;
                if (cmd_q == CMD_CASET) begin
                  col_start_d = win_word[16 +: ADDR_W];
                  col_end_d   = win_word[0 +: ADDR_W];
                end else begin
                  row_start_d = win_word[16 +: ADDR_W];
                  row_end_d   = win_word[0 +: ADDR_W];
                end
              end
            end
            CMD_MADCTL: madctl_d = bus.i_spi_data;
            CMD_COLMOD: begin
              if (bus.i_spi_data[2:0] == 3'b110) begin
                bpp18_d = 1'b1;
              end else if (bus.i_spi_data[2:0] == 3'b101) begin
                bpp18_d = 1'b0;
              end
            end
            default: ;
          endcase
        end

        ST_PIXEL: begin
          if (!bpp18_q) begin
            if (pix_cnt_q == 2'd0) begin
              pix_hi_d  = bus.i_spi_data;
              pix_cnt_d = 2'd1;
            end else begin
              // RGB565 {hi,lo} -> RGB666, replicating the MSB into the new LSB.
              pix_done  = 1'b1;
              pix_cnt_d = 2'd0;
              pix_new   = {pix_hi_q[7:3], pix_hi_q[7],
                           pix_hi_q[2:0], bus.i_spi_data[7:5],
                           bus.i_spi_data[4:0], bus.i_spi_data[4]};
            end
          end else begin
            if (pix_cnt_q == 2'd0) begin
              pix_hi_d  = bus.i_spi_data;
              pix_cnt_d = 2'd1;
            end else if (pix_cnt_q == 2'd1) begin
              pix_mid_d = bus.i_spi_data[7:2];
              pix_cnt_d = 2'd2;
            end else begin
              pix_done  = 1'b1;
              pix_cnt_d = 2'd0;
              pix_new   = {pix_hi_q[7:2], pix_mid_q, bus.i_spi_data[7:2]};
            end
          end
        end

        default: state_d = ST_CMD;
      endcase
    end

    if (pix_done) begin
      if (!pix_valid_q || bus.i_pix_ready) begin
        pix_data_d  = pix_new;
        pix_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    sram_clr_req_d = (clr_cnt_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_CMD;
      cmd_q          <= '0;
      arg_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      pix_hi_q       <= '0;
      pix_mid_q      <= '0;
      shadow_q       <= '0;
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      ramwr_start_q  <= 1'b0;
      col_start_q    <= '0;
      col_end_q      <= '0;
      row_start_q    <= '0;
      row_end_q      <= '0;
      waddr_set_q    <= 1'b0;
      clr_cnt_q      <= '0;
      sram_clr_req_q <= 1'b0;
      disp_on_q      <= 1'b0;
      invert_q       <= 1'b0;
      madctl_q       <= '0;
      bpp18_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      arg_cnt_q      <= arg_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      pix_hi_q       <= pix_hi_d;
      pix_mid_q      <= pix_mid_d;
      shadow_q       <= shadow_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      ramwr_start_q  <= ramwr_start_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      row_start_q    <= row_start_d;
      row_end_q      <= row_end_d;
      waddr_set_q    <= waddr_set_d;
      clr_cnt_q      <= clr_cnt_d;
      sram_clr_req_q <= sram_clr_req_d;
      disp_on_q      <= disp_on_d;
      invert_q       <= invert_d;
      madctl_q       <= madctl_d;
      bpp18_q        <= bpp18_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.o_pix_data     = pix_data_q;
  assign bus.o_pix_valid    = pix_valid_q;
  assign bus.o_ramwr_start  = ramwr_start_q;
  assign bus.o_col_start    = col_start_q;
  assign bus.o_col_end      = col_end_q;
  assign bus.o_row_start    = row_start_q;
  assign bus.o_row_end      = row_end_q;
  assign bus.o_waddr_set    = waddr_set_q;
  assign bus.o_sram_clr_req = sram_clr_req_q;
  assign bus.o_disp_on      = disp_on_q;
  assign bus.o_invert       = invert_q;
  assign bus.o_madctl       = madctl_q;
  assign bus.o_bpp18        = bpp18_q;
  assign bus.o_overflow     = overflow_q;

endmodule

// File: tb/tb_spi_lcd_cmd_decoder.sv
// Testbench for spi_lcd_cmd_decoder: register-state vector table, window/pixel/overflow/reset sequences.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: i_pix_ready driven per sequence; accepted pixels checked against an expected queue.
module tb_spi_lcd_cmd_decoder;

  logic i_clk;
  logic i_rst;

  spi_lcd_cmd_decoder_if #(.ADDR_W(16)) bus ();

  spi_lcd_cmd_decoder #(.ADDR_W(16), .CLR_PULSE_LEN(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int waddr_hi_cnt = 0;
  int ramwr_hi_cnt = 0;
  int clr_hi_cnt = 0;
  logic [17:0] exp_q [$];

  typedef struct {
    logic [7:0] dat;
    logic       cs;
    logic       disp;
    logic       inv;
    logic [7:0] mad;
    logic       bpp;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pulse counters and the pixel scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (bus.o_waddr_set)    waddr_hi_cnt++;
      if (bus.o_ramwr_start)  ramwr_hi_cnt++;
      if (bus.o_sram_clr_req) clr_hi_cnt++;
      if (bus.o_pix_valid && bus.i_pix_ready) begin
        if (exp_q.size() == 0) begin
          check("pix_unexpected", {14'd0, bus.o_pix_data}, 32'hFFFF_FFFF);
        end else begin
          check("pix_data", {14'd0, bus.o_pix_data}, {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    bus.i_spi_data   = b;
    bus.i_spi_rxdone = 1'b1;
    @(posedge i_clk); #1;
    bus.i_spi_rxdone = 1'b0;
  endtask

  task automatic cs_release();
    @(posedge i_clk); #1;
    bus.i_spi_csreleased = 1'b1;
    @(posedge i_clk); #1;
    bus.i_spi_csreleased = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic cs, input logic disp,
                              input logic inv, input logic [7:0] mad, input logic bpp);
    vec_t v;
    v.dat = d; v.cs = cs; v.disp = disp; v.inv = inv; v.mad = mad; v.bpp = bpp;
    return v;
  endfunction

  initial begin
    // Byte / CS stimulus with the display state expected after each entry.
    vecs[0]  = mk(8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0); // SWRESET
    vecs[1]  = mk(8'h29, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); // DISPON
    vecs[2]  = mk(8'h21, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); // INVON
    vecs[3]  = mk(8'h36, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0); // MADCTL
    vecs[4]  = mk(8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[5]  = mk(8'h3A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0); // COLMOD 18bpp
    vecs[6]  = mk(8'h66, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
    vecs[7]  = mk(8'h3A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1); // COLMOD illegal
    vecs[8]  = mk(8'h77, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1);
    vecs[9]  = mk(8'h3A, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1); // COLMOD 16bpp
    vecs[10] = mk(8'h55, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[11] = mk(8'hB1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0); // FRMCTR1, 3 args
    vecs[12] = mk(8'h28, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[13] = mk(8'h20, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[14] = mk(8'h01, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[15] = mk(8'h28, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0); // DISPOFF
    vecs[16] = mk(8'hC1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0); // PWCTR2, 1 arg
    vecs[17] = mk(8'h29, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    vecs[18] = mk(8'h20, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0); // INVOFF
    vecs[19] = mk(8'h36, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0); // MADCTL aborted
    vecs[20] = mk(8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    vecs[21] = mk(8'h29, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    vecs[22] = mk(8'hD9, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0); // NVCTR1, 1 arg
    vecs[23] = mk(8'h21, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    vecs[24] = mk(8'h21, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[25] = mk(8'h28, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);

    bus.i_spi_data       = 8'h00;
    bus.i_spi_rxdone     = 1'b0;
    bus.i_spi_csreleased = 1'b0;
    bus.i_pix_ready      = 1'b1;
    i_rst                = 1'b1;
    wait_cycles(3);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Reset state
    check("rst_pix_valid", {31'd0, bus.o_pix_valid}, 32'd0);
    check("rst_pix_data",  {14'd0, bus.o_pix_data},  32'd0);
    check("rst_col_start", {16'd0, bus.o_col_start}, 32'd0);
    check("rst_row_end",   {16'd0, bus.o_row_end},   32'd0);
    check("rst_disp_on",   {31'd0, bus.o_disp_on},   32'd0);
    check("rst_madctl",    {24'd0, bus.o_madctl},    32'd0);
    check("rst_bpp18",     {31'd0, bus.o_bpp18},     32'd0);
    check("rst_overflow",  {31'd0, bus.o_overflow},  32'd0);
    check("rst_clr_req",   {31'd0, bus.o_sram_clr_req}, 32'd0);

    // Window commits: outputs change only on the fourth byte
    send_byte(8'h2A); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    @(negedge i_clk);
    check("caset_partial_col_start", {16'd0, bus.o_col_start}, 32'd0);
    send_byte(8'h7F);
    send_byte(8'h2B); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h9F);
    wait_cycles(2);
    check("col_start", {16'd0, bus.o_col_start}, 32'h0010);
    check("col_end",   {16'd0, bus.o_col_end},   32'h007F);
    check("row_start", {16'd0, bus.o_row_start}, 32'h0020);
    check("row_end",   {16'd0, bus.o_row_end},   32'h009F);
    check("waddr_set_cycles", waddr_hi_cnt, 32'd2);

    // Aborted CASET keeps the window; next byte is a command
    send_byte(8'h2A); send_byte(8'h00); send_byte(8'h10);
    cs_release();
    send_byte(8'h29);
    @(negedge i_clk);
    check("abort_col_start", {16'd0, bus.o_col_start}, 32'h0010);
    check("abort_col_end",   {16'd0, bus.o_col_end},   32'h007F);
    check("abort_waddr",     waddr_hi_cnt, 32'd2);
    check("abort_dispon",    {31'd0, bus.o_disp_on}, 32'd1);

    // Register-state vector table
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].cs) cs_release();
      else            send_byte(vecs[i].dat);
      @(negedge i_clk);
      check($sformatf("vec%0d.disp", i), {31'd0, bus.o_disp_on}, {31'd0, vecs[i].disp});
      check($sformatf("vec%0d.inv", i),  {31'd0, bus.o_invert},  {31'd0, vecs[i].inv});
      check($sformatf("vec%0d.mad", i),  {24'd0, bus.o_madctl},  {24'd0, vecs[i].mad});
      check($sformatf("vec%0d.bpp", i),  {31'd0, bus.o_bpp18},   {31'd0, vecs[i].bpp});
    end

    // 16 bpp pixels with ready high
    ramwr_hi_cnt = 0;
    send_byte(8'h3A); send_byte(8'h55);
    send_byte(8'h2C); send_byte(8'hF8);
    exp_q.push_back(18'h3F000);
    send_byte(8'h00); send_byte(8'h07);
    exp_q.push_back(18'h00FC0);
    send_byte(8'hE0);
    wait_cycles(3);
    check("p16_queue_empty", exp_q.size(), 32'd0);
    check("p16_ramwr_pulses", ramwr_hi_cnt, 32'd1);
    check("p16_valid_cleared", {31'd0, bus.o_pix_valid}, 32'd0);
    cs_release();

    // 18 bpp pixel
    send_byte(8'h3A); send_byte(8'h66);
    @(negedge i_clk);
    check("p18_bpp18", {31'd0, bus.o_bpp18}, 32'd1);
    send_byte(8'h2C); send_byte(8'hFC); send_byte(8'h00);
    exp_q.push_back(18'h3F021);
    send_byte(8'h84);
    wait_cycles(3);
    check("p18_queue_empty", exp_q.size(), 32'd0);
    cs_release();

    // Backpressure: second pixel dropped, first held
    bus.i_pix_ready = 1'b0;
    send_byte(8'h3A); send_byte(8'h55);
    send_byte(8'h2C); send_byte(8'hF8); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'hE0);
    @(negedge i_clk);
    check("ovf_held_valid", {31'd0, bus.o_pix_valid}, 32'd1);
    check("ovf_held_data",  {14'd0, bus.o_pix_data},  32'h3F000);
    check("ovf_flag",       {31'd0, bus.o_overflow},  32'd1);
    cs_release();
    @(negedge i_clk);
    check("ovf_sticky_after_cs", {31'd0, bus.o_overflow}, 32'd1);
    check("cs_keeps_valid",      {31'd0, bus.o_pix_valid}, 32'd1);

    // SWRESET: overflow cleared, clear pulse four cycles
    send_byte(8'h29);
    clr_hi_cnt = 0;
    send_byte(8'h01);
    @(negedge i_clk);
    check("swrst_overflow", {31'd0, bus.o_overflow},     32'd0);
    check("swrst_disp_on",  {31'd0, bus.o_disp_on},      32'd0);
    check("swrst_clr_req",  {31'd0, bus.o_sram_clr_req}, 32'd1);
    wait_cycles(10);
    check("swrst_clr_len", clr_hi_cnt, 32'd4);

    // Second SWRESET two cycles in restarts the count: 2 + 4 cycles high
    clr_hi_cnt = 0;
    send_byte(8'h01);
    send_byte(8'h01);
    wait_cycles(12);
    check("swrst_restart_len", clr_hi_cnt, 32'd6);

    // Release backpressure: held pixel is accepted
    exp_q.push_back(18'h3F000);
    bus.i_pix_ready = 1'b1;
    wait_cycles(3);
    check("held_accepted", exp_q.size(), 32'd0);
    check("held_valid_cleared", {31'd0, bus.o_pix_valid}, 32'd0);

    // Same-cycle CS release and byte: the byte is discarded
    @(posedge i_clk); #1;
    bus.i_spi_data       = 8'h29;
    bus.i_spi_rxdone     = 1'b1;
    bus.i_spi_csreleased = 1'b1;
    @(posedge i_clk); #1;
    bus.i_spi_rxdone     = 1'b0;
    bus.i_spi_csreleased = 1'b0;
    @(negedge i_clk);
    check("cs_wins_disp_on", {31'd0, bus.o_disp_on}, 32'd0);

    // PWCTR1 args ignored, then async reset mid-CASET
    send_byte(8'h36); send_byte(8'h5A);
    send_byte(8'hC0); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h29);
    @(negedge i_clk);
    check("pwctr1_dispon", {31'd0, bus.o_disp_on}, 32'd1);
    check("pwctr1_madctl", {24'd0, bus.o_madctl},  32'h5A);
    send_byte(8'h2A); send_byte(8'h00); send_byte(8'h10);
    @(posedge i_clk); #3;
    i_rst = 1'b1;
    #1;
    check("arst_disp_on",   {31'd0, bus.o_disp_on},   32'd0);
    check("arst_madctl",    {24'd0, bus.o_madctl},    32'd0);
    check("arst_col_start", {16'd0, bus.o_col_start}, 32'd0);
    check("arst_row_end",   {16'd0, bus.o_row_end},   32'd0);
    check("arst_pix_data",  {14'd0, bus.o_pix_data},  32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    send_byte(8'h29);
    @(negedge i_clk);
    check("post_rst_dispon", {31'd0, bus.o_disp_on}, 32'd1);
    check("post_rst_col",    {16'd0, bus.o_col_start}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
